alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read ports, the multi-cycle
// ALU and the write-back mux.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic [2:0]       SELECT;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;
    logic             ZERO;
    logic             CARRY;

    modport master (
        output START, SELECT, DATA1, DATA2,
        input  BUSY, DONE, RESULT, ZERO, CARRY
    );

    modport slave (
        input  START, SELECT, DATA1, DATA2,
        output BUSY, DONE, RESULT, ZERO, CARRY
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle FWD/ADD/AND/OR/SUB, bit-serial SLL/SRA and a
// shift-add multiply, with START/BUSY/DONE handshake and CARRY/ZERO flags.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RESET_N,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sra_q, sra_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     add_w, sub_w, mul_sum;
    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   sh_v, res_v;
    logic               sh_out, c_v, fin;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sra_d    = sra_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        fin      = 1'b0;
        res_v    = '0;
        c_v      = 1'b0;

        amt     = bus.DATA2[SHW-1:0];
        add_w   = {1'b0, bus.DATA1} + {1'b0, bus.DATA2};
        sub_w   = {1'b0, bus.DATA1} + {1'b0, ~bus.DATA2} + {{WIDTH{1'b0}}, 1'b1};
        sh_v    = sra_q ? {a_q[WIDTH-1], a_q[WIDTH-1:1]} : {a_q[WIDTH-2:0], 1'b0};
        sh_out  = sra_q ? a_q[0] : a_q[WIDTH-1];
        // Multiplier sits in the low half of acc and is consumed LSB first.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    case (bus.SELECT)
                        3'b000: begin fin = 1'b1; res_v = bus.DATA2; end
                        3'b001: begin fin = 1'b1; res_v = add_w[WIDTH-1:0]; c_v = add_w[WIDTH]; end
                        3'b010: begin fin = 1'b1; res_v = bus.DATA1 & bus.DATA2; end
                        3'b011: begin fin = 1'b1; res_v = bus.DATA1 | bus.DATA2; end
                        3'b100: begin fin = 1'b1; res_v = sub_w[WIDTH-1:0]; c_v = sub_w[WIDTH]; end
                        3'b101, 3'b110: begin
                            if (amt == '0) begin
                                fin   = 1'b1;
                                res_v = bus.DATA1;
                            end else begin
                                a_d     = bus.DATA1;
                                cnt_d   = CW'(amt);
                                sra_d   = bus.SELECT[1];
                                state_d = SHIFT;
                            end
                        end
                        default: begin
                            a_d     = bus.DATA1;
                            acc_d   = {{WIDTH{1'b0}}, bus.DATA2};
                            cnt_d   = CW'(WIDTH);
                            state_d = MUL;
                        end
                    endcase
                end
            end
            SHIFT: begin
                a_d   = sh_v;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    res_v   = sh_v;
                    c_v     = sh_out;
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    fin     = 1'b1;
                    res_v   = acc_d[WIDTH-1:0];
                    c_v     = |acc_d[2*WIDTH-1:WIDTH];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            result_d = res_v;
            zero_d   = (res_v == '0);
            carry_d  = c_v;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            a_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sra_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sra_q    <= sra_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    assign bus.BUSY   = (state_q != IDLE);
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
    assign bus.ZERO   = zero_q;
    assign bus.CARRY  = carry_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16: expectations queued at
// issue, checked (result, flags, latency) when DONE appears.
module tb_alu_seq;
    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    alu_seq_if #(.WIDTH(8))  b8();
    alu_seq_if #(.WIDTH(16)) b16();

    alu_seq #(.WIDTH(8))  dut8  (.CLK(CLK), .RESET_N(RESET_N), .bus(b8));
    alu_seq #(.WIDTH(16)) dut16 (.CLK(CLK), .RESET_N(RESET_N), .bus(b16));

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          lat;
        int          c0;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        int         lat;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];
    vec_t vq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboards: pop on every DONE, flag any DONE nobody asked for.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET_N && b8.DONE !== 1'b0) begin
            if (q8.size() == 0) chk("spurious_done8", 32'(b8.DONE), 32'd0);
            else begin
                e = q8.pop_front();
                chk("result8", 32'(b8.RESULT), 32'(e.res));
                chk("zero8",   32'(b8.ZERO),   32'(e.res == 16'd0));
                chk("carry8",  32'(b8.CARRY),  32'(e.c));
                chk("busy_at_done8", 32'(b8.BUSY), 32'd0);
                chk("latency8", cyc - e.c0, e.lat);
            end
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RESET_N && b16.DONE !== 1'b0) begin
            if (q16.size() == 0) chk("spurious_done16", 32'(b16.DONE), 32'd0);
            else begin
                e = q16.pop_front();
                chk("result16", 32'(b16.RESULT), 32'(e.res));
                chk("zero16",   32'(b16.ZERO),   32'(e.res == 16'd0));
                chk("carry16",  32'(b16.CARRY),  32'(e.c));
                chk("busy_at_done16", 32'(b16.BUSY), 32'd0);
                chk("latency16", cyc - e.c0, e.lat);
            end
        end
    end

    task automatic wait_idle(input bit w16);
        int n = 0;
        while ((w16 ? b16.BUSY : b8.BUSY) !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(w16 ? b16.BUSY : b8.BUSY), 32'd0);
    endtask

    // Called at a negedge; START is presented for exactly one rising edge.
    task automatic issue(input bit w16, input logic [2:0] s, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] r, input logic c, input int lat);
        exp_t e;
        wait_idle(w16);
        e.res = r; e.c = c; e.lat = lat; e.c0 = cyc;
        if (w16) begin
            b16.START = 1'b1; b16.SELECT = s; b16.DATA1 = a; b16.DATA2 = b;
            q16.push_back(e);
        end else begin
            b8.START = 1'b1; b8.SELECT = s; b8.DATA1 = a[7:0]; b8.DATA2 = b[7:0];
            q8.push_back(e);
        end
        @(negedge CLK);
        b8.START = 1'b0;
        b16.START = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            chk("drain_timeout", q8.size() + q16.size(), 0);
            q8.delete();
            q16.delete();
        end
    endtask

    task automatic add_vec(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic c, input int lat);
        vec_t v;
        v.sel = s; v.a = a; v.b = b; v.r = r; v.c = c; v.lat = lat;
        vq.push_back(v);
    endtask

    // Independent behavioural reference for WIDTH=8: {carry, result}.
    function automatic logic [8:0] model8(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        int amt;
        amt = int'(b[2:0]);
        case (s)
            3'd0: return {1'b0, b};
            3'd1: return {1'b0, a} + {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a} + {1'b0, ~b} + 9'd1;
            3'd5: if (amt == 0) return {1'b0, a}; else return {a[8-amt], 8'(a << amt)};
            3'd6: if (amt == 0) return {1'b0, a}; else return {a[amt-1], 8'($signed(a) >>> amt)};
            default: begin
                p = {8'h00, a} * {8'h00, b};
                return {|p[15:8], p[7:0]};
            end
        endcase
    endfunction

    function automatic int lat8(input logic [2:0] s, input logic [7:0] b);
        if (s == 3'd7) return 9;
        if ((s == 3'd5 || s == 3'd6) && b[2:0] != 3'd0) return int'(b[2:0]) + 1;
        return 1;
    endfunction

    initial begin
        logic [8:0] m;
        logic [2:0] s;
        logic [7:0] a, b;

        b8.START = 0;  b8.SELECT = 0;  b8.DATA1 = 0;  b8.DATA2 = 0;
        b16.START = 0; b16.SELECT = 0; b16.DATA1 = 0; b16.DATA2 = 0;

        add_vec(3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1);
        add_vec(3'd4, 8'h03, 8'h05, 8'hFE, 1'b0, 1);
        add_vec(3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
        add_vec(3'd3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1);
        add_vec(3'd4, 8'h05, 8'h03, 8'h02, 1'b1, 1);
        add_vec(3'd1, 8'h80, 8'h80, 8'h00, 1'b1, 1);
        add_vec(3'd0, 8'h55, 8'h00, 8'h00, 1'b0, 1);
        add_vec(3'd5, 8'h81, 8'h03, 8'h08, 1'b0, 4);
        add_vec(3'd6, 8'h80, 8'h0A, 8'hE0, 1'b0, 3);
        add_vec(3'd5, 8'h5A, 8'h08, 8'h5A, 1'b0, 1);
        add_vec(3'd6, 8'h81, 8'h01, 8'hC0, 1'b1, 2);
        add_vec(3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 8);
        add_vec(3'd6, 8'h7F, 8'h07, 8'h00, 1'b1, 8);
        add_vec(3'd7, 8'h0F, 8'h11, 8'hFF, 1'b0, 9);
        add_vec(3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 9);

        repeat (2) @(negedge CLK);
        chk("rst_result8", 32'(b8.RESULT), 32'd0);
        chk("rst_zero8",   32'(b8.ZERO),   32'd1);
        chk("rst_carry8",  32'(b8.CARRY),  32'd0);
        chk("rst_busy8",   32'(b8.BUSY),   32'd0);
        chk("rst_done8",   32'(b8.DONE),   32'd0);
        chk("rst_zero16",  32'(b16.ZERO),  32'd1);
        RESET_N = 1'b1;
        @(negedge CLK);

        issue(0, 3'd0, 16'h0011, 16'h005A, 16'h005A, 1'b0, 1);
        chk("fwd_busy", 32'(b8.BUSY), 32'd0);
        drain();
        RESET_N = 1'b0;
        #1;
        chk("pulse_rst_result", 32'(b8.RESULT), 32'd0);
        chk("pulse_rst_zero",   32'(b8.ZERO),   32'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        foreach (vq[i])
            issue(0, vq[i].sel, 16'(vq[i].a), 16'(vq[i].b), 16'(vq[i].r), vq[i].c, vq[i].lat);
        drain();

        for (int i = 0; i < 40; i++) begin
            s = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            m = model8(s, a, b);
            issue(0, s, 16'(a), 16'(b), 16'(m[7:0]), m[8], lat8(s, b));
        end
        drain();

        // Operand changes and START pulses during MUL must not disturb it.
        issue(0, 3'd7, 16'h000F, 16'h0011, 16'h00FF, 1'b0, 9);
        b8.DATA1 = 8'hFF; b8.DATA2 = 8'hFF; b8.SELECT = 3'd0; b8.START = 1'b1;
        repeat (3) @(negedge CLK);
        b8.START = 1'b0;
        drain();
        repeat (12) @(negedge CLK);
        chk("hold_result", 32'(b8.RESULT), 32'h00FF);

        // Reset in the 4th busy cycle of MUL kills it with no DONE.
        issue(0, 3'd7, 16'h0010, 16'h0010, 16'h0000, 1'b1, 9);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        chk("midmul_rst_busy",   32'(b8.BUSY),   32'd0);
        chk("midmul_rst_done",   32'(b8.DONE),   32'd0);
        chk("midmul_rst_result", 32'(b8.RESULT), 32'd0);
        q8.delete();
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (15) @(negedge CLK);
        chk("midmul_after_result", 32'(b8.RESULT), 32'd0);
        chk("midmul_after_zero",   32'(b8.ZERO),   32'd1);

        issue(1, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
        issue(1, 3'd5, 16'h0001, 16'h000F, 16'h8000, 1'b0, 16);
        issue(1, 3'd7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 17);
        issue(1, 3'd6, 16'h8001, 16'h0004, 16'hF800, 1'b0, 5);
        drain();
        repeat (4) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
